// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Round-robin arbiter for the single write port of the register file.
//   It grants at most one of N_REQ write sources per cycle. It drives registered
//   wr_en/wr_addr/wr_data to the register file, and it acknowledges each served
//   request with a one-cycle ack pulse. A saturating counter records the cycles
//   in which more than one request was eligible.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   req         per-requester write request (level)
//   req_addr    packed destination indices, slot i = [i*ADDR_W +: ADDR_W]
//   req_data    packed write data, slot i = [i*DATA_W +: DATA_W]
//   ack         one-hot, registered, one-cycle "request served" pulse
//   wr_en       register-file write enable (low for writes to x0)
//   wr_addr     register-file write index (holds its value while idle)
//   wr_data     register-file write data (holds its value while idle)
//   contention  saturating count of cycles with more than one eligible request
module rf_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [CNT_W-1:0]        contention
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Unpacked views of the packed request slots
  logic [ADDR_W-1:0] slotAddr [N_REQ];
  logic [DATA_W-1:0] slotData [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : gSlot
      assign slotAddr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign slotData[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [N_REQ-1:0]  ackReg, ackNext;
  logic              wrEnReg, wrEnNext;
  logic [ADDR_W-1:0] wrAddrReg;
  logic [DATA_W-1:0] wrDataReg;
  logic [CNT_W-1:0]  cntReg;
  logic [PTR_W-1:0]  rrPtrReg, rrPtrNext;

  logic [N_REQ-1:0]  elig;
  logic [PTR_W-1:0]  winIdx;
  logic [PTR_W-1:0]  candIdx;
  logic              anyElig;
  logic              multiElig;
  int                scanIdx;

  // The requester being acked this cycle still has req high for the write just
  // served, so it is kept out of this cycle's arbitration.
  assign elig = req & ~ackReg;

  // Clearing the lowest set bit leaves something only if two or more bits are set.
  assign multiElig = |(elig & (elig - N_REQ'(1)));

  // Round-robin search. The scan runs from the farthest offset down to rrPtr.
  // Each later hit overwrites earlier ones, so the requester nearest to rrPtr
  // in the upward, wrapping direction wins.
  always_comb begin
    winIdx  = '0;
    anyElig = 1'b0;
    scanIdx = 0;
    candIdx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scanIdx = int'(rrPtrReg) + k;
      if (scanIdx >= N_REQ) scanIdx = scanIdx - N_REQ;
      candIdx = PTR_W'(scanIdx);
      if (elig[candIdx]) begin
        winIdx  = candIdx;
        anyElig = 1'b1;
      end
    end
  end

  always_comb begin
    ackNext   = '0;
    wrEnNext  = 1'b0;
    rrPtrNext = rrPtrReg;
    if (anyElig) begin
      ackNext   = N_REQ'(1) << winIdx;
      // Writes to x0 still complete the handshake but never reach the file.
      wrEnNext  = (slotAddr[winIdx] != '0);
      rrPtrNext = (winIdx == PTR_W'(N_REQ - 1)) ? '0 : winIdx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ackReg    <= '0;
      wrEnReg   <= 1'b0;
      wrAddrReg <= '0;
      wrDataReg <= '0;
      cntReg    <= '0;
      rrPtrReg  <= '0;
    end else begin
      ackReg   <= ackNext;
      wrEnReg  <= wrEnNext;
      rrPtrReg <= rrPtrNext;
      if (anyElig) begin
        wrAddrReg <= slotAddr[winIdx];
        wrDataReg <= slotData[winIdx];
      end
      if (multiElig && (cntReg != '1)) begin
        cntReg <= cntReg + CNT_W'(1);
      end
    end
  end

  assign ack        = ackReg;
  assign wr_en      = wrEnReg;
  assign wr_addr    = wrAddrReg;
  assign wr_data    = wrDataReg;
  assign contention = cntReg;

endmodule
